// File: rtl/edf_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : edf_mux_arbiter_if
// Purpose  : Request/grant bundle between requesters and the EDF mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface edf_mux_arbiter_if #(
    parameter int DL_W = 8
) ();
    logic [3:0]        req;
    logic              done;
    logic [4*DL_W-1:0] rel_deadline;
    logic              miss_clr;
    logic [1:0]        sel;
    logic [3:0]        grant;
    logic              busy;
    logic [3:0]        miss;

    modport master (
        output req, done, rel_deadline, miss_clr,
        input  sel, grant, busy, miss
    );

    modport slave (
        input  req, done, rel_deadline, miss_clr,
        output sel, grant, busy, miss
    );
endinterface
`default_nettype wire

// File: rtl/edf_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edf_mux_arbiter
// Purpose  : Earliest-deadline-first arbiter driving a 4:1 datapath mux select.
// Revision : 1.0 - initial release
// ============================================================================
module edf_mux_arbiter #(
    parameter int DL_W     = 8,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 255
) (
    input  logic              aclk,
    input  logic              aresetn,
    edf_mux_arbiter_if.slave  bus
);
    localparam logic [0:0]        c_idle     = 1'b0;
    localparam logic [0:0]        c_busy     = 1'b1;
    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_hold_one = HOLD_W'(1);
    localparam logic [DL_W-1:0]   c_dl_one   = DL_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [3:0]        r_pending;
    logic [DL_W-1:0]   r_cd [4];
    logic [HOLD_W-1:0] r_hold;
    logic [1:0]        r_sel;
    logic [3:0]        r_miss;

    logic [1:0]        w_win;
    logic [DL_W-1:0]   w_best;
    logic              w_any;
    logic              w_release;
    logic              w_start;
    logic              w_busy;
    logic [3:0]        w_grant;

    // Smallest countdown among pending requesters; strict compare keeps the lowest index on ties.
    always_comb begin
        w_win  = 2'd0;
        w_best = '1;
        w_any  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i] && (!w_any || (r_cd[i] < w_best))) begin
                w_any  = 1'b1;
                w_best = r_cd[i];
                w_win  = 2'(i);
            end
        end
    end

    assign w_start   = (r_state == c_idle) && w_any;
    assign w_release = (r_state == c_busy) && (bus.done || (r_hold == c_max_hold));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_any)     w_state_nxt = c_busy;
            c_busy:  if (w_release) w_state_nxt = c_idle;
            default:                w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == c_busy);
        w_grant = 4'b0000;
        if (w_busy) begin
            w_grant[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pending <= 4'b0000;
            r_hold    <= '0;
            r_sel     <= 2'd0;
            r_miss    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_cd[i] <= '0;
            end
        end else begin
            if (w_start) begin
                r_sel <= w_win;
            end
            r_hold <= (r_state == c_idle) ? '0 : r_hold + c_hold_one;

            for (int i = 0; i < 4; i++) begin
                if (w_release && (r_sel == 2'(i))) begin
                    r_pending[i] <= 1'b0;
                end else if (bus.req[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_cd[i]      <= bus.rel_deadline[i*DL_W +: DL_W];
                end else if (r_pending[i] && !w_grant[i] && (r_cd[i] != '0)) begin
                    r_cd[i] <= r_cd[i] - c_dl_one;
                end

                // A miss observed this cycle outranks a simultaneous clear.
                if (r_pending[i] && !w_grant[i] && (r_cd[i] == '0)) begin
                    r_miss[i] <= 1'b1;
                end else if (bus.miss_clr) begin
                    r_miss[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.sel   = r_sel;
    assign bus.grant = w_grant;
    assign bus.busy  = w_busy;
    assign bus.miss  = r_miss;
endmodule
`default_nettype wire
